// File: rtl/io_bus_arbiter.sv
// Two-master IO bus arbiter (M0 = CPU, M1 = DMA) with round-robin arbitration,
// bounded bus locking and a programmable number of wait states per access.
module io_bus_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int MAX_LOCK    = 4
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  input  logic        m0_rd_i,
  input  logic        m0_wr_i,
  input  logic        m1_rd_i,
  input  logic        m1_wr_i,
  input  logic        m0_lock_i,
  input  logic        m1_lock_i,
  input  logic [15:0] m0_addr_i,
  input  logic [15:0] m1_addr_i,
  input  logic [15:0] m0_dout_i,
  input  logic [15:0] m1_dout_i,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic [15:0] m0_din_o,
  output logic [15:0] m1_din_o,
  output logic [15:0] bus_addr_o,
  output logic [15:0] bus_dout_o,
  output logic        bus_rd_o,
  output logic        bus_wr_o,
  input  logic [15:0] bus_din_i,
  output logic        owner_o
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [3:0] LOCK_MAX  = 4'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [3:0]  lock_cnt;
  logic        lock_flag;

  logic        lock_hold;
  logic        win;
  logic        win_rd;
  logic        win_wr;
  logic [15:0] win_addr;
  logic [15:0] win_dout;
  logic        owner_lock;

  // Winner selection: a sole requester wins; on a tie the owner keeps the bus
  // only while its lock is live, otherwise the other master gets its turn.
  always_comb begin
    lock_hold = lock_flag && (lock_cnt < LOCK_MAX);
    win       = owner_o;
    if (m0_req_i && m1_req_i) begin
      win = lock_hold ? owner_o : ~owner_o;
    end else if (m0_req_i) begin
      win = 1'b0;
    end else if (m1_req_i) begin
      win = 1'b1;
    end
    win_rd     = win ? m1_rd_i   : m0_rd_i;
    win_wr     = win ? m1_wr_i   : m0_wr_i;
    win_addr   = win ? m1_addr_i : m0_addr_i;
    win_dout   = win ? m1_dout_i : m0_dout_i;
    owner_lock = owner_o ? m1_lock_i : m0_lock_i;
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      lock_cnt   <= 4'd0;
      lock_flag  <= 1'b0;
      owner_o    <= 1'b1;
      bus_addr_o <= 16'h0000;
      bus_dout_o <= 16'h0000;
      bus_rd_o   <= 1'b0;
      bus_wr_o   <= 1'b0;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      m0_din_o   <= 16'h0000;
      m1_din_o   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            owner_o    <= win;
            bus_addr_o <= win_addr;
            bus_dout_o <= win_dout;
            bus_wr_o   <= win_wr;
            bus_rd_o   <= win_rd & ~win_wr;
            wait_cnt   <= WAIT_INIT;
            state      <= ACCESS;
            // A new owner starts with no lock history.
            if (win != owner_o) begin
              lock_cnt  <= 4'd0;
              lock_flag <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state    <= DONE;
            bus_rd_o <= 1'b0;
            bus_wr_o <= 1'b0;
            if (owner_o) begin
              m1_ack_o <= 1'b1;
              if (bus_rd_o) m1_din_o <= bus_din_i;
            end else begin
              m0_ack_o <= 1'b1;
              if (bus_rd_o) m0_din_o <= bus_din_i;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          m0_ack_o <= 1'b0;
          m1_ack_o <= 1'b0;
          state    <= IDLE;
          // Lock is sampled at the ack; the count saturates at MAX_LOCK.
          if (owner_lock) begin
            lock_flag <= 1'b1;
            if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 4'd1;
          end else begin
            lock_flag <= 1'b0;
            lock_cnt  <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: directed transactions push expected
// completions; monitors pop and compare on every ack.
module tb_io_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m0_rd, m0_wr, m0_lock;
  logic        m1_req, m1_rd, m1_wr, m1_lock;
  logic [15:0] m0_addr, m0_dout, m1_addr, m1_dout, bus_din;
  logic        m0_ack, m1_ack, bus_rd, bus_wr, owner;
  logic [15:0] m0_din, m1_din, bus_addr, bus_dout;

  logic        z_req;
  logic [15:0] z_bus_din;
  logic        z_ack0, z_ack1, z_bus_rd, z_bus_wr, z_owner;
  logic [15:0] z_din0, z_din1, z_bus_addr, z_bus_dout;

  io_bus_arbiter #(.WAIT_STATES(1), .MAX_LOCK(4)) u_dut (
    .sys_clk_i(clk), .sys_rst_i(rst_n),
    .m0_req_i(m0_req), .m1_req_i(m1_req),
    .m0_rd_i(m0_rd), .m0_wr_i(m0_wr), .m1_rd_i(m1_rd), .m1_wr_i(m1_wr),
    .m0_lock_i(m0_lock), .m1_lock_i(m1_lock),
    .m0_addr_i(m0_addr), .m1_addr_i(m1_addr),
    .m0_dout_i(m0_dout), .m1_dout_i(m1_dout),
    .m0_ack_o(m0_ack), .m1_ack_o(m1_ack),
    .m0_din_o(m0_din), .m1_din_o(m1_din),
    .bus_addr_o(bus_addr), .bus_dout_o(bus_dout),
    .bus_rd_o(bus_rd), .bus_wr_o(bus_wr),
    .bus_din_i(bus_din), .owner_o(owner)
  );

  io_bus_arbiter #(.WAIT_STATES(0), .MAX_LOCK(4)) u_dut_ws0 (
    .sys_clk_i(clk), .sys_rst_i(rst_n),
    .m0_req_i(z_req), .m1_req_i(1'b0),
    .m0_rd_i(1'b1), .m0_wr_i(1'b0), .m1_rd_i(1'b0), .m1_wr_i(1'b0),
    .m0_lock_i(1'b0), .m1_lock_i(1'b0),
    .m0_addr_i(16'h0100), .m1_addr_i(16'h0000),
    .m0_dout_i(16'h0000), .m1_dout_i(16'h0000),
    .m0_ack_o(z_ack0), .m1_ack_o(z_ack1),
    .m0_din_o(z_din0), .m1_din_o(z_din1),
    .bus_addr_o(z_bus_addr), .bus_dout_o(z_bus_dout),
    .bus_rd_o(z_bus_rd), .bus_wr_o(z_bus_wr),
    .bus_din_i(z_bus_din), .owner_o(z_owner)
  );

  typedef struct {
    int          master;
    int          rd_n;
    int          wr_n;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [15:0] din0;
    logic [15:0] din1;
  } exp_t;

  exp_t        q[$];
  logic [15:0] qz[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_n, wr_n;
  int          zc, zprev, zrd;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push(input int m, input int rn, input int wn, input logic [15:0] a,
                               input logic [15:0] d, input logic [15:0] d0, input logic [15:0] d1);
    exp_t e;
    e.master = m; e.rd_n = rn; e.wr_n = wn;
    e.addr = a; e.dout = d; e.din0 = d0; e.din1 = d1;
    q.push_back(e);
  endfunction

  // Main DUT monitor: counts strobe cycles and checks each completion.
  initial begin
    exp_t e;
    rd_n = 0;
    wr_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_n = 0;
        wr_n = 0;
      end else begin
        if (bus_rd) rd_n++;
        if (bus_wr) wr_n++;
        if (m0_ack && m1_ack) begin
          checks++; errors++;
          $display("FAIL both_ack: got both acks high, required one");
        end else if (m0_ack || m1_ack) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: got ack m%0d, required none", m1_ack);
          end else begin
            e = q.pop_front();
            chk("ack_master", 32'(m1_ack), 32'(e.master));
            chk("owner", 32'(owner), 32'(e.master));
            chk("rd_cycles", 32'(rd_n), 32'(e.rd_n));
            chk("wr_cycles", 32'(wr_n), 32'(e.wr_n));
            chk("bus_addr", 32'(bus_addr), 32'(e.addr));
            chk("bus_dout", 32'(bus_dout), 32'(e.dout));
            chk("m0_din", 32'(m0_din), 32'(e.din0));
            chk("m1_din", 32'(m1_din), 32'(e.din1));
          end
          rd_n = 0;
          wr_n = 0;
        end
      end
    end
  end

  // Zero-wait-state DUT monitor: ack spacing, read data and M1 isolation.
  initial begin
    logic [15:0] ed;
    zc = 0; zprev = -1; zrd = 0;
    forever begin
      @(negedge clk);
      zc++;
      if (!rst_n) begin
        zrd = 0;
        zprev = -1;
      end else begin
        if (z_bus_rd) zrd++;
        if (z_ack1) begin
          checks++; errors++;
          $display("FAIL ws0_m1_ack: got m1 ack, required none");
        end
        if (z_ack0) begin
          if (qz.size() == 0) begin
            checks++; errors++;
            $display("FAIL ws0_unexpected_ack: got ack, required none");
          end else begin
            ed = qz.pop_front();
            chk("ws0_m0_din", 32'(z_din0), 32'(ed));
            chk("ws0_m1_din", 32'(z_din1), 32'h0);
            chk("ws0_rd_cycles", 32'(zrd), 32'd1);
            if (zprev >= 0) chk("ws0_ack_spacing", 32'(zc - zprev), 32'd3);
          end
          zprev = zc;
          zrd = 0;
        end
      end
    end
  end

  // Caller must be one step after a rising edge with the arbiter in IDLE.
  task automatic drive(input int m, input logic rd, input logic wr, input logic lock,
                       input logic [15:0] addr, input logic [15:0] dout, output int lat);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    if (m == 0) begin
      m0_rd = rd; m0_wr = wr; m0_lock = lock; m0_addr = addr; m0_dout = dout; m0_req = 1'b1;
    end else begin
      m1_rd = rd; m1_wr = wr; m1_lock = lock; m1_addr = addr; m1_dout = dout; m1_req = 1'b1;
    end
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = (m == 0) ? m0_ack : m1_ack;
    end
    lat = n;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ack_timeout_m%0d: got no ack after %0d cycles, required ack", m, n);
    end
    @(posedge clk);
    #1;
    if (m == 0) begin
      m0_req = 1'b0; m0_lock = 1'b0;
    end else begin
      m1_req = 1'b0; m1_lock = 1'b0;
    end
  endtask

  initial begin
    int lat0, lat1, lat, dummy0, dummy1;
    logic z_done;
    rst_n = 1'b0;
    m0_req = 0; m0_rd = 0; m0_wr = 0; m0_lock = 0; m0_addr = 0; m0_dout = 0;
    m1_req = 0; m1_rd = 0; m1_wr = 0; m1_lock = 0; m1_addr = 0; m1_dout = 0;
    bus_din = 16'h0000;
    z_req = 1'b0;
    z_bus_din = 16'h3C3C;

    repeat (3) @(negedge clk);
    chk("rst_m0_ack", 32'(m0_ack), 32'h0);
    chk("rst_m1_ack", 32'(m1_ack), 32'h0);
    chk("rst_bus_rd", 32'(bus_rd), 32'h0);
    chk("rst_bus_wr", 32'(bus_wr), 32'h0);
    chk("rst_bus_addr", 32'(bus_addr), 32'h0);
    chk("rst_bus_dout", 32'(bus_dout), 32'h0);
    chk("rst_m0_din", 32'(m0_din), 32'h0);
    chk("rst_m1_din", 32'(m1_din), 32'h0);
    chk("rst_owner", 32'(owner), 32'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous writes after reset: M0 first, then M1.
    push(0, 0, 2, 16'h2000, 16'hAAAA, 16'h0000, 16'h0000);
    push(1, 0, 2, 16'h3000, 16'h1234, 16'h0000, 16'h0000);
    fork
      drive(0, 1'b0, 1'b1, 1'b0, 16'h2000, 16'hAAAA, lat0);
      drive(1, 1'b0, 1'b1, 1'b0, 16'h3000, 16'h1234, lat1);
    join
    chk("tie_m0_latency", 32'(lat0), 32'd4);
    chk("tie_m1_latency", 32'(lat1), 32'd8);

    // Single read, ack at cycle WAIT_STATES+2.
    bus_din = 16'h00A5;
    push(0, 2, 0, 16'h6B00, 16'h0000, 16'h00A5, 16'h0000);
    drive(0, 1'b1, 1'b0, 1'b0, 16'h6B00, 16'h0000, lat);
    chk("read_latency", 32'(lat), 32'd4);

    // rd and wr together: write wins, read data untouched.
    bus_din = 16'h5555;
    push(0, 0, 2, 16'h7010, 16'hBEEF, 16'h00A5, 16'h0000);
    drive(0, 1'b1, 1'b1, 1'b0, 16'h7010, 16'hBEEF, lat);

    // Neither rd nor wr: no strobes, still acked.
    push(1, 0, 0, 16'h0042, 16'h0000, 16'h00A5, 16'h0000);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0000, lat);
    chk("noop_latency", 32'(lat), 32'd4);

    // Reset mid-access: strobes drop at once, M1 completes after release.
    bus_din = 16'h0F0F;
    push(1, 2, 0, 16'h1000, 16'h0000, 16'h0000, 16'h0F0F);
    fork
      drive(1, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, lat);
      begin
        @(posedge clk);
        #3;
        chk("rd_before_reset", 32'(bus_rd), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rd_async_reset", 32'(bus_rd), 32'h0);
        chk("addr_async_reset", 32'(bus_addr), 32'h0);
        chk("ack_async_reset", 32'(m1_ack), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    chk("post_reset_latency", 32'(lat), 32'd6);

    // Locked M1 vs continuously requesting M0.
    bus_din = 16'h0BAD;
    for (int i = 0; i < 4; i++)
      push(1, 0, 2, 16'h4000 + 16'(i), 16'hC000 + 16'(i), 16'h0000, 16'h0F0F);
    push(0, 2, 0, 16'h5000, 16'h0000, 16'h0BAD, 16'h0F0F);
    push(1, 0, 2, 16'h4004, 16'hC004, 16'h0BAD, 16'h0F0F);
    push(0, 2, 0, 16'h5001, 16'h0000, 16'h0BAD, 16'h0F0F);
    fork
      begin
        for (int i = 0; i < 5; i++)
          drive(1, 1'b0, 1'b1, 1'b1, 16'h4000 + 16'(i), 16'hC000 + 16'(i), dummy1);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < 2; j++)
          drive(0, 1'b1, 1'b0, 1'b0, 16'h5000 + 16'(j), 16'h0000, dummy0);
      end
    join

    // Zero wait states: back-to-back reads from a held request.
    for (int k = 0; k < 4; k++) qz.push_back(16'h3C3C);
    z_req = 1'b1;
    z_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (qz.size() == 0) begin
        z_done = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    z_req = 1'b0;
    chk("ws0_all_acked", 32'(z_done), 32'h1);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    chk("ws0_scoreboard_empty", 32'(qz.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
